l2_input_sched: RTL and testbench
=================================

# l2_input_sched

Cycle-level scheduler for the L2 core's input side. It picks one of the pending input channels (response, forward, flush, ongoing flush, fence, CPU request) per transaction, issues a one-hot `do_*` grant to `l2_fsm`, and holds it until the FSM signals completion. The block also consumes the source handshake and applies an aging counter so CPU requests cannot be starved by forward or flush traffic. It sits between `l2_interfaces` / `l2_regs` and `l2_fsm`.

## Interface
Parameters:
- `STARVE_LIMIT`, default 8: number of lost arbitrations after which an eligible CPU request is promoted.
- `CNT_W`, default 4: width of the aging counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `l2_rsp_in_valid_int`, `l2_fwd_in_valid_int`, `l2_cpu_req_valid_int`, `l2_flush_valid_int`, `l2_fence_valid_int` in 1 each: source valids.
- `l2_rsp_in_ready_int`, `l2_fwd_in_ready_int`, `l2_cpu_req_ready_int`, `l2_flush_ready_int`, `l2_fence_ready_int` out 1 each: single-cycle consume pulses.
- `ongoing_flush` in 1: a flush sweep is still in progress.
- `ongoing_fence` in 1: a fence is still in progress.
- `ongoing_atomic` in 1: an atomic is in progress.
- `fwd_stall` in 1: forward blocked on an MSHR entry.
- `set_conflict` in 1: CPU request blocked by a same-set MSHR entry.
- `evict_stall` in 1: CPU request blocked by an eviction.
- `mshr_cnt` in `MSHR_BITS_P1: count of free MSHR entries.
- `sched_done` in 1: pulse from the FSM; the current grant is finished.
- `do_rsp`, `do_fwd`, `do_ongoing_flush`, `do_flush`, `do_fence`, `do_cpu_req` out 1 each: registered one-hot grant.
- `sched_busy` out 1: a grant is outstanding.
- `cpu_promoted` out 1: the current `do_cpu_req` grant was won through aging.

## Operation
Eligibility (combinational):
- rsp: valid.
- fwd: valid && !fwd_stall && !ongoing_atomic.
- ongoing_flush: ongoing_flush && mshr_cnt!=0.
- flush: valid && !ongoing_flush && !ongoing_atomic && mshr_cnt==`N_MSHR.
- fence: valid && !ongoing_fence && mshr_cnt==`N_MSHR.
- cpu: valid && !set_conflict && !evict_stall && !ongoing_flush && !ongoing_fence && mshr_cnt!=0.

Fixed priority:
- Normal order: rsp > fwd > ongoing_flush > flush > fence > cpu.
- When `age_cnt>=STARVE_LIMIT` and cpu is eligible, cpu moves directly below rsp.

FSM states:
- IDLE:
  - If any channel is eligible, assert the winner's `*_ready` combinationally in this cycle. `ongoing_flush` has no ready port.
  - Register the one-hot grant and go to BUSY.
  - If nothing is eligible, stay in IDLE.
- BUSY:
  - Hold the `do_*` grant and `sched_busy` high. All readies are 0.
  - On `sched_done`, clear the grant and go to IDLE. No new grant is issued in that same cycle.

Aging counter `age_cnt` (CNT_W bits), updated on each grant cycle in IDLE:
- cpu granted: clear to 0.
- cpu_req valid but another channel granted: increment, saturating at STARVE_LIMIT.
- Whenever `l2_cpu_req_valid_int` is 0 (any state): clear to 0.
- `cpu_promoted` registers along with `do_cpu_req` and is 1 only when aging decided the win.

Boundary rules:
- `sched_done` while in IDLE is ignored.
- A valid that drops before it is granted is simply not granted. No state is kept for it.
- mshr_cnt==0: only rsp and fwd can be granted.
- Reset mid-BUSY: next cycle state=IDLE, all outputs 0, age_cnt=0.

## Timing
- Reset values: every `do_*`, `*_ready`, `sched_busy`, `cpu_promoted` = 0; age_cnt=0; state=IDLE.
- Grant latency: eligible valid in IDLE at cycle N → ready pulse in N → `do_*` high in N+1.
- Done: `sched_done` at cycle M → `do_*` low in M+1. The earliest next ready pulse is M+1, so the minimum gap between back-to-back grants is 1 idle-visible cycle.
- Exactly one `do_*` is high at a time; all are 0 in IDLE. At most one ready pulses per cycle.

## Test plan
- rsp and cpu valid together in IDLE → `l2_rsp_in_ready_int` pulses in cycle 0, `do_rsp`=1 in cycle 1. After `sched_done`, cpu is granted with ready in the cycle after done.
- fwd valid with fwd_stall=1, cpu valid, mshr_cnt=2 → cpu granted. Then drop fwd_stall → fwd granted on the next IDLE cycle.
- STARVE_LIMIT=3, fwd held valid continuously, cpu valid → fwd wins 3 times. The 4th grant is `do_cpu_req`=1 with `cpu_promoted`=1, and age_cnt returns to 0.
- flush valid with mshr_cnt=`N_MSHR-1 → not granted. Set mshr_cnt=`N_MSHR → `l2_flush_ready_int` pulses. Then ongoing_flush=1 → `do_ongoing_flush` granted repeatedly, and cpu is blocked throughout.
- Assert `rst` during BUSY (`do_fwd`=1) → next cycle all outputs 0. A `sched_done` arriving afterwards in IDLE produces no state change.

Source files
------------

// File: rtl/l2_input_sched.sv
// Input-side scheduler for the L2 core: picks one eligible input channel per
// transaction, pulses its ready, and holds a one-hot grant until l2_fsm finishes.
module l2_input_sched #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4,
    parameter int N_MSHR       = 4,
    parameter int MSHR_W       = $clog2(N_MSHR) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l2_rsp_in_valid_int,
    input  logic              l2_fwd_in_valid_int,
    input  logic              l2_cpu_req_valid_int,
    input  logic              l2_flush_valid_int,
    input  logic              l2_fence_valid_int,
    output logic              l2_rsp_in_ready_int,
    output logic              l2_fwd_in_ready_int,
    output logic              l2_cpu_req_ready_int,
    output logic              l2_flush_ready_int,
    output logic              l2_fence_ready_int,
    input  logic              ongoing_flush,
    input  logic              ongoing_fence,
    input  logic              ongoing_atomic,
    input  logic              fwd_stall,
    input  logic              set_conflict,
    input  logic              evict_stall,
    input  logic [MSHR_W-1:0] mshr_cnt,
    input  logic              sched_done,
    output logic              do_rsp,
    output logic              do_fwd,
    output logic              do_ongoing_flush,
    output logic              do_flush,
    output logic              do_fence,
    output logic              do_cpu_req,
    output logic              sched_busy,
    output logic              cpu_promoted
);

    localparam int CH_RSP    = 0;
    localparam int CH_FWD    = 1;
    localparam int CH_OFLUSH = 2;
    localparam int CH_FLUSH  = 3;
    localparam int CH_FENCE  = 4;
    localparam int CH_CPU    = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [5:0]       grant_reg, grant_next;
    logic             prom_reg, prom_next;
    logic [CNT_W-1:0] age_reg, age_next;

    logic [5:0] elig;
    logic [5:0] win;
    logic       starved;
    logic       promote_win;
    logic       mshr_full;
    logic       mshr_any;

    assign mshr_full = (mshr_cnt == MSHR_W'(N_MSHR));
    assign mshr_any  = (mshr_cnt != '0);

    always_comb begin
        elig            = '0;
        elig[CH_RSP]    = l2_rsp_in_valid_int;
        elig[CH_FWD]    = l2_fwd_in_valid_int && !fwd_stall && !ongoing_atomic;
        elig[CH_OFLUSH] = ongoing_flush && mshr_any;
        elig[CH_FLUSH]  = l2_flush_valid_int && !ongoing_flush && !ongoing_atomic && mshr_full;
        elig[CH_FENCE]  = l2_fence_valid_int && !ongoing_fence && mshr_full;
        elig[CH_CPU]    = l2_cpu_req_valid_int && !set_conflict && !evict_stall &&
                          !ongoing_flush && !ongoing_fence && mshr_any;
    end

    // A starved CPU request jumps everything except responses, which must
    // always drain to avoid deadlocking the coherence protocol.
    always_comb begin
        win     = '0;
        starved = (age_reg >= CNT_W'(STARVE_LIMIT)) && elig[CH_CPU];
        if (elig[CH_RSP])         win[CH_RSP]    = 1'b1;
        else if (starved)         win[CH_CPU]    = 1'b1;
        else if (elig[CH_FWD])    win[CH_FWD]    = 1'b1;
        else if (elig[CH_OFLUSH]) win[CH_OFLUSH] = 1'b1;
        else if (elig[CH_FLUSH])  win[CH_FLUSH]  = 1'b1;
        else if (elig[CH_FENCE])  win[CH_FENCE]  = 1'b1;
        else if (elig[CH_CPU])    win[CH_CPU]    = 1'b1;
    end

    // Promotion only counts when it actually beat a normally-higher channel.
    assign promote_win = starved && !elig[CH_RSP] && (|elig[CH_FENCE:CH_FWD]);

    always_comb begin
        state_next           = state_reg;
        grant_next           = grant_reg;
        prom_next            = prom_reg;
        age_next             = age_reg;
        l2_rsp_in_ready_int  = 1'b0;
        l2_fwd_in_ready_int  = 1'b0;
        l2_flush_ready_int   = 1'b0;
        l2_fence_ready_int   = 1'b0;
        l2_cpu_req_ready_int = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|win) begin
                    l2_rsp_in_ready_int  = win[CH_RSP];
                    l2_fwd_in_ready_int  = win[CH_FWD];
                    l2_flush_ready_int   = win[CH_FLUSH];
                    l2_fence_ready_int   = win[CH_FENCE];
                    l2_cpu_req_ready_int = win[CH_CPU];
                    grant_next           = win;
                    prom_next            = win[CH_CPU] && promote_win;
                    state_next           = BUSY;
                    if (win[CH_CPU])
                        age_next = '0;
                    else if (l2_cpu_req_valid_int)
                        age_next = (age_reg >= CNT_W'(STARVE_LIMIT)) ? CNT_W'(STARVE_LIMIT)
                                                                     : age_reg + CNT_W'(1);
                end
            end
            BUSY: begin
                if (sched_done) begin
                    grant_next = '0;
                    prom_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!l2_cpu_req_valid_int)
            age_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            prom_reg  <= 1'b0;
            age_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            prom_reg  <= prom_next;
            age_reg   <= age_next;
        end
    end

    assign do_rsp           = grant_reg[CH_RSP];
    assign do_fwd           = grant_reg[CH_FWD];
    assign do_ongoing_flush = grant_reg[CH_OFLUSH];
    assign do_flush         = grant_reg[CH_FLUSH];
    assign do_fence         = grant_reg[CH_FENCE];
    assign do_cpu_req       = grant_reg[CH_CPU];
    assign sched_busy       = (state_reg == BUSY);
    assign cpu_promoted     = prom_reg;

endmodule

// File: tb/tb_l2_input_sched.sv
// Bench for l2_input_sched: table vectors, hand-written multi-cycle sequences,
// and a randomized run against a priority-list reference model.
module tb_l2_input_sched;

    localparam int LIMIT  = 3;
    localparam int CNT_W  = 4;
    localparam int N_MSHR = 4;
    localparam int MSHR_W = 3;

    // Input flag masks for mk(): one bit per source condition.
    localparam logic [10:0] RSP = 11'h400, FWD = 11'h200, CPU = 11'h100, FL  = 11'h080,
                            FE  = 11'h040, OFL = 11'h020, OFE = 11'h010, OAT = 11'h008,
                            FST = 11'h004, SCF = 11'h002, EVS = 11'h001;
    // Ready vector bits: rsp, fwd, flush, fence, cpu.
    localparam logic [4:0] R_NONE = 5'b00000, R_RSP = 5'b00001, R_FWD = 5'b00010,
                           R_FL = 5'b00100, R_FE = 5'b01000, R_CPU = 5'b10000;
    // Grant vector bits: rsp, fwd, ongoing_flush, flush, fence, cpu.
    localparam logic [5:0] D_NONE = 6'b000000, D_RSP = 6'b000001, D_FWD = 6'b000010,
                           D_OFL = 6'b000100, D_FL = 6'b001000, D_FE = 6'b010000,
                           D_CPU = 6'b100000;

    typedef struct {
        logic rsp, fwd, cpu, fl, fe, ofl, ofe, oat, fst, scf, evs;
        logic [MSHR_W-1:0] mshr;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [4:0] rdy;
        logic [5:0] dov;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rsp_v, fwd_v, cpu_v, fl_v, fe_v;
    logic rsp_r, fwd_r, cpu_r, fl_r, fe_r;
    logic ofl, ofe, oat, fst, scf, evs;
    logic [MSHR_W-1:0] mshr_cnt;
    logic sched_done;
    logic d_rsp, d_fwd, d_ofl, d_fl, d_fe, d_cpu, busy, prom;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    l2_input_sched #(
        .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W), .N_MSHR(N_MSHR), .MSHR_W(MSHR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .l2_rsp_in_valid_int(rsp_v), .l2_fwd_in_valid_int(fwd_v),
        .l2_cpu_req_valid_int(cpu_v), .l2_flush_valid_int(fl_v),
        .l2_fence_valid_int(fe_v),
        .l2_rsp_in_ready_int(rsp_r), .l2_fwd_in_ready_int(fwd_r),
        .l2_cpu_req_ready_int(cpu_r), .l2_flush_ready_int(fl_r),
        .l2_fence_ready_int(fe_r),
        .ongoing_flush(ofl), .ongoing_fence(ofe), .ongoing_atomic(oat),
        .fwd_stall(fst), .set_conflict(scf), .evict_stall(evs),
        .mshr_cnt(mshr_cnt), .sched_done(sched_done),
        .do_rsp(d_rsp), .do_fwd(d_fwd), .do_ongoing_flush(d_ofl),
        .do_flush(d_fl), .do_fence(d_fe), .do_cpu_req(d_cpu),
        .sched_busy(busy), .cpu_promoted(prom)
    );

    function automatic in_t mk(input logic [10:0] f, input int m);
        in_t x;
        {x.rsp, x.fwd, x.cpu, x.fl, x.fe, x.ofl, x.ofe, x.oat, x.fst, x.scf, x.evs} = f;
        x.mshr = MSHR_W'(m);
        return x;
    endfunction

    task automatic apply(input in_t x);
        {rsp_v, fwd_v, cpu_v, fl_v, fe_v, ofl, ofe, oat, fst, scf, evs} =
            {x.rsp, x.fwd, x.cpu, x.fl, x.fe, x.ofl, x.ofe, x.oat, x.fst, x.scf, x.evs};
        mshr_cnt = x.mshr;
    endtask

    function automatic logic [4:0] rdy_vec();
        return {cpu_r, fe_r, fl_r, fwd_r, rsp_r};
    endfunction

    function automatic logic [5:0] do_vec();
        return {d_cpu, d_fe, d_fl, d_ofl, d_fwd, d_rsp};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Reference model: eligibility straight from the rules, arbitration as a
    // walk down an ordered priority list that aging may reorder.
    function automatic int first_of(input logic [5:0] e, input int order[6]);
        for (int i = 0; i < 6; i++)
            if (e[order[i]]) return order[i];
        return -1;
    endfunction

    function automatic int model_win(input in_t x, input int age, output bit promoted);
        logic [5:0] e;
        int normal_order[6];
        int aged_order[6];
        int w, wn;
        normal_order = '{0, 1, 2, 3, 4, 5};
        aged_order   = '{0, 5, 1, 2, 3, 4};
        e[0] = x.rsp;
        e[1] = x.fwd && !x.fst && !x.oat;
        e[2] = x.ofl && (x.mshr != 0);
        e[3] = x.fl && !x.ofl && !x.oat && (x.mshr == N_MSHR);
        e[4] = x.fe && !x.ofe && (x.mshr == N_MSHR);
        e[5] = x.cpu && !x.scf && !x.evs && !x.ofl && !x.ofe && (x.mshr != 0);
        wn = first_of(e, normal_order);
        w  = (age >= LIMIT && e[5]) ? first_of(e, aged_order) : wn;
        promoted = (w == 5) && (wn != 5);
        return w;
    endfunction

    function automatic logic [4:0] exp_rdy(input int w);
        case (w)
            0: return R_RSP;
            1: return R_FWD;
            3: return R_FL;
            4: return R_FE;
            5: return R_CPU;
            default: return R_NONE;
        endcase
    endfunction

    function automatic logic [5:0] exp_do(input int w);
        return (w < 0) ? D_NONE : (6'b000001 << w);
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        sched_done = 1'b0;
        apply(mk(11'h000, N_MSHR));
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One granted transaction, starting and ending at a negedge in IDLE.
    task automatic grant_once(input string tag, input logic [4:0] er, input logic [5:0] ed,
                              input logic ep);
        #1;
        check({tag, "_ready"}, rdy_vec(), er);
        @(negedge clk);
        check({tag, "_grant"}, do_vec(), ed);
        check({tag, "_prom"}, prom, ep);
        sched_done = 1'b1;
        @(negedge clk);
        sched_done = 1'b0;
    endtask

    vec_t vecs[$];

    int  m_age;
    bit  m_busy;
    int  m_grant;
    bit  m_prom;

    initial begin
        vecs.push_back('{"rsp_over_cpu",   mk(RSP|CPU, 4),       R_RSP,  D_RSP});
        vecs.push_back('{"fwd_stalled",    mk(FWD|FST|CPU, 2),   R_CPU,  D_CPU});
        vecs.push_back('{"fwd_atomic",     mk(FWD|OAT|CPU, 2),   R_CPU,  D_CPU});
        vecs.push_back('{"flush_not_full", mk(FL, 3),            R_NONE, D_NONE});
        vecs.push_back('{"flush_full",     mk(FL, 4),            R_FL,   D_FL});
        vecs.push_back('{"oflush_vs_cpu",  mk(OFL|CPU, 2),       R_NONE, D_OFL});
        vecs.push_back('{"oflush_mshr0",   mk(OFL|FWD, 0),       R_FWD,  D_FWD});
        vecs.push_back('{"fence_vs_cpu",   mk(FE|CPU, 4),        R_FE,   D_FE});
        vecs.push_back('{"ofence_blocks",  mk(FE|OFE|CPU, 4),    R_NONE, D_NONE});
        vecs.push_back('{"cpu_mshr0",      mk(CPU, 0),           R_NONE, D_NONE});
        vecs.push_back('{"rsp_mshr0",      mk(RSP|CPU, 0),       R_RSP,  D_RSP});
        vecs.push_back('{"cpu_setconf",    mk(CPU|SCF, 3),       R_NONE, D_NONE});
        vecs.push_back('{"cpu_evict",      mk(CPU|EVS, 3),       R_NONE, D_NONE});
        vecs.push_back('{"flush_vs_fence", mk(FL|FE, 4),         R_FL,   D_FL});
        vecs.push_back('{"flush_atomic",   mk(FL|FE|OAT, 4),     R_FE,   D_FE});
        vecs.push_back('{"fwd_over_flush", mk(FWD|FL|FE|CPU, 4), R_FWD,  D_FWD});

        rst = 1'b1;
        sched_done = 1'b0;
        apply(mk(11'h000, N_MSHR));
        reset_dut();
        @(negedge clk);
        check("reset_grant", do_vec(), D_NONE);
        check("reset_ready", rdy_vec(), R_NONE);
        check("reset_busy", busy, 1'b0);
        check("reset_prom", prom, 1'b0);

        foreach (vecs[i]) begin
            apply(vecs[i].in);
            #1;
            check({vecs[i].name, "_ready"}, rdy_vec(), vecs[i].rdy);
            @(negedge clk);
            check({vecs[i].name, "_grant"}, do_vec(), vecs[i].dov);
            check({vecs[i].name, "_busy"}, busy, |vecs[i].dov);
            apply(mk(11'h000, N_MSHR));
            sched_done = 1'b1;
            @(negedge clk);
            sched_done = 1'b0;
            check({vecs[i].name, "_released"}, do_vec(), D_NONE);
        end

        // rsp wins, then cpu readies in the very cycle after done.
        apply(mk(RSP|CPU, 4));
        #1;
        check("b2b_rsp_ready", rdy_vec(), R_RSP);
        @(negedge clk);
        check("b2b_rsp_grant", do_vec(), D_RSP);
        apply(mk(CPU, 4));
        sched_done = 1'b1;
        @(negedge clk);
        sched_done = 1'b0;
        check("b2b_after_done", do_vec(), D_NONE);
        grant_once("b2b_cpu", R_CPU, D_CPU, 1'b0);
        apply(mk(11'h000, N_MSHR));
        @(negedge clk);

        // Stalled fwd lets cpu through, then fwd wins once unstalled.
        apply(mk(FWD|FST|CPU, 2));
        #1;
        check("stall_cpu_ready", rdy_vec(), R_CPU);
        @(negedge clk);
        check("stall_cpu_grant", do_vec(), D_CPU);
        apply(mk(FWD|CPU, 2));
        sched_done = 1'b1;
        @(negedge clk);
        sched_done = 1'b0;
        grant_once("unstall_fwd", R_FWD, D_FWD, 1'b0);
        apply(mk(11'h000, N_MSHR));
        @(negedge clk);

        // Aging: fwd wins LIMIT times, then cpu promoted, then counter back to 0.
        apply(mk(FWD|CPU, 2));
        for (int g = 0; g < LIMIT; g++)
            grant_once($sformatf("age_fwd%0d", g), R_FWD, D_FWD, 1'b0);
        grant_once("age_cpu_promoted", R_CPU, D_CPU, 1'b1);
        grant_once("age_fwd_after", R_FWD, D_FWD, 1'b0);
        apply(mk(11'h000, N_MSHR));
        @(negedge clk);

        // Flush gated by full MSHR, then ongoing flush blocks cpu.
        apply(mk(FL, 3));
        #1;
        check("flush_wait_ready", rdy_vec(), R_NONE);
        @(negedge clk);
        check("flush_wait_grant", do_vec(), D_NONE);
        apply(mk(FL, 4));
        grant_once("flush_go", R_FL, D_FL, 1'b0);
        apply(mk(OFL|CPU, 2));
        for (int g = 0; g < 3; g++)
            grant_once($sformatf("oflush%0d", g), R_NONE, D_OFL, 1'b0);
        apply(mk(11'h000, N_MSHR));
        @(negedge clk);

        // Reset in the middle of a fwd grant.
        apply(mk(FWD, 2));
        @(negedge clk);
        check("rst_pre_grant", do_vec(), D_FWD);
        apply(mk(11'h000, N_MSHR));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_grant", do_vec(), D_NONE);
        check("rst_mid_busy", busy, 1'b0);
        sched_done = 1'b1;
        @(negedge clk);
        sched_done = 1'b0;
        check("done_in_idle_grant", do_vec(), D_NONE);
        check("done_in_idle_busy", busy, 1'b0);
        apply(mk(FWD, 2));
        grant_once("post_rst_fwd", R_FWD, D_FWD, 1'b0);

        // Randomized run against the reference model.
        reset_dut();
        m_age = 0; m_busy = 0; m_grant = -1; m_prom = 0;
        for (int c = 0; c < 600; c++) begin
            in_t x;
            int  w;
            bit  p;
            logic dn;
            @(negedge clk);
            check($sformatf("rnd%0d_grant", c), do_vec(), exp_do(m_grant));
            check($sformatf("rnd%0d_busy", c), busy, m_busy);
            check($sformatf("rnd%0d_prom", c), prom, m_prom);
            x.rsp = ($urandom_range(0, 5) == 0);
            x.fwd = ($urandom_range(0, 1) == 0);
            x.cpu = ($urandom_range(0, 7) != 0);
            x.fl  = ($urandom_range(0, 3) == 0);
            x.fe  = ($urandom_range(0, 3) == 0);
            x.ofl = ($urandom_range(0, 5) == 0);
            x.ofe = ($urandom_range(0, 5) == 0);
            x.oat = ($urandom_range(0, 5) == 0);
            x.fst = ($urandom_range(0, 3) == 0);
            x.scf = ($urandom_range(0, 5) == 0);
            x.evs = ($urandom_range(0, 5) == 0);
            x.mshr = ($urandom_range(0, 1) == 0) ? MSHR_W'(N_MSHR)
                                                 : MSHR_W'($urandom_range(0, N_MSHR));
            dn = ($urandom_range(0, 1) == 0);
            apply(x);
            sched_done = dn;
            w = model_win(x, m_age, p);
            #1;
            check($sformatf("rnd%0d_ready", c), rdy_vec(), m_busy ? R_NONE : exp_rdy(w));
            @(posedge clk);
            if (m_busy) begin
                if (dn) begin
                    m_busy = 0; m_grant = -1; m_prom = 0;
                end
            end else if (w >= 0) begin
                m_busy = 1; m_grant = w; m_prom = p;
                if (w == 5) m_age = 0;
                else if (x.cpu) m_age = (m_age + 1 > LIMIT) ? LIMIT : m_age + 1;
            end
            if (!x.cpu) m_age = 0;
        end
        sched_done = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
